// File: rtl/block_reader_pkg.sv
`default_nettype none
// ============================================================================
// block_reader_pkg : FSM encoding and 8x8 block geometry shared by the reader
// Rev 1.0
// ============================================================================
package block_reader_pkg;

  localparam int c_BLK_DIM = 8;
  localparam int c_BLK_PIX = c_BLK_DIM * c_BLK_DIM;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_HI = 3'd1,
    ST_RD_LO = 3'd2,
    ST_LATCH = 3'd3,
    ST_OUT   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/block_addr_gen.sv
`default_nettype none
// ============================================================================
// block_addr_gen : byte address of the current pixel from block/pixel counters
// Rev 1.0
// ============================================================================
module block_addr_gen
  import block_reader_pkg::*;
#(
  parameter int H_RES     = 160,
  parameter int BUFF_BITS = 16,
  parameter int BASE_ADDR = 1,
  parameter int BX_W      = 5,
  parameter int BY_W      = 4
) (
  input  logic [2:0]           px,
  input  logic [2:0]           py,
  input  logic [BX_W-1:0]      bx,
  input  logic [BY_W-1:0]      by,
  input  logic                 lo_sel,
  output logic [BUFF_BITS-1:0] addr
);

  logic [BUFF_BITS-1:0] w_row;
  logic [BUFF_BITS-1:0] w_col;
  logic [BUFF_BITS-1:0] w_lin;

  // All arithmetic is modulo 2^BUFF_BITS, which gives the required truncation.
  always_comb begin
    w_row = BUFF_BITS'(by) * BUFF_BITS'(c_BLK_DIM) + BUFF_BITS'(py);
    w_col = BUFF_BITS'(bx) * BUFF_BITS'(c_BLK_DIM) + BUFF_BITS'(px);
    w_lin = w_row * BUFF_BITS'(H_RES) + w_col;
    addr  = BUFF_BITS'(BASE_ADDR) + (w_lin << 1) + BUFF_BITS'(lo_sel);
  end

endmodule
`default_nettype wire

// File: rtl/block_reader.sv
`default_nettype none
// ============================================================================
// block_reader : reads an RGB565 frame buffer out in 8x8 block raster order
// Rev 1.0
// ============================================================================
module block_reader
  import block_reader_pkg::*;
#(
  parameter int H_RES     = 160,
  parameter int V_RES     = 120,
  parameter int BUFF_BITS = 16,
  parameter int BASE_ADDR = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_captured,
  output logic [BUFF_BITS-1:0] rd_addr,
  output logic                 rd_en,
  input  logic [7:0]           rd_data,
  output logic [15:0]          pix_data,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic                 blk_first,
  output logic                 blk_last,
  output logic                 frame_done,
  output logic                 busy
);

  localparam int c_BLKS_X = H_RES / c_BLK_DIM;
  localparam int c_BLKS_Y = V_RES / c_BLK_DIM;
  localparam int c_BX_W   = (c_BLKS_X > 1) ? $clog2(c_BLKS_X) : 1;
  localparam int c_BY_W   = (c_BLKS_Y > 1) ? $clog2(c_BLKS_Y) : 1;

  state_t              r_state;
  state_t              w_next;
  logic [2:0]          r_px;
  logic [2:0]          r_py;
  logic [c_BX_W-1:0]   r_bx;
  logic [c_BY_W-1:0]   r_by;
  logic [7:0]          r_hi;
  logic                r_fc_prev;
  logic                r_armed;
  logic                w_start;
  logic                w_lo_sel;
  logic                w_px_wrap;
  logic                w_py_wrap;
  logic                w_bx_wrap;
  logic                w_by_wrap;
  logic                w_last;
  logic                w_adv;
  logic [BUFF_BITS-1:0] w_addr;

  // r_armed requires frame_captured to be seen low after reset, so a level
  // held high across reset cannot masquerade as a fresh rising edge.
  assign w_start   = frame_captured & ~r_fc_prev & r_armed;
  assign w_px_wrap = (r_px == 3'(c_BLK_DIM - 1));
  assign w_py_wrap = (r_py == 3'(c_BLK_DIM - 1));
  assign w_bx_wrap = (r_bx == c_BX_W'(c_BLKS_X - 1));
  assign w_by_wrap = (r_by == c_BY_W'(c_BLKS_Y - 1));
  assign w_last    = w_px_wrap & w_py_wrap & w_bx_wrap & w_by_wrap;
  assign w_adv     = (r_state == ST_OUT) & pix_ready;

  block_addr_gen #(
    .H_RES     (H_RES),
    .BUFF_BITS (BUFF_BITS),
    .BASE_ADDR (BASE_ADDR),
    .BX_W      (c_BX_W),
    .BY_W      (c_BY_W)
  ) u_addr_gen (
    .px     (r_px),
    .py     (r_py),
    .bx     (r_bx),
    .by     (r_by),
    .lo_sel (w_lo_sel),
    .addr   (w_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_next = ST_RD_HI;
      ST_RD_HI: w_next = ST_RD_LO;
      ST_RD_LO: w_next = ST_LATCH;
      ST_LATCH: w_next = ST_OUT;
      ST_OUT:   if (pix_ready) w_next = w_last ? ST_DONE : ST_RD_HI;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_en      = 1'b0;
    w_lo_sel   = 1'b0;
    pix_valid  = 1'b0;
    frame_done = 1'b0;
    case (r_state)
      ST_RD_HI: rd_en = 1'b1;
      ST_RD_LO: begin
        rd_en    = 1'b1;
        w_lo_sel = 1'b1;
      end
      ST_OUT:   pix_valid  = 1'b1;
      ST_DONE:  frame_done = 1'b1;
      default:  ;
    endcase
  end

  assign busy      = (r_state != ST_IDLE);
  assign rd_addr   = rd_en ? w_addr : '0;
  assign blk_first = pix_valid & (r_px == 3'd0) & (r_py == 3'd0);
  assign blk_last  = pix_valid & w_px_wrap & w_py_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fc_prev <= 1'b0;
      r_armed   <= 1'b0;
      r_hi      <= 8'd0;
      pix_data  <= 16'd0;
      r_px      <= '0;
      r_py      <= '0;
      r_bx      <= '0;
      r_by      <= '0;
    end else begin
      r_fc_prev <= frame_captured;
      if (!frame_captured)      r_armed  <= 1'b1;
      if (r_state == ST_RD_LO)  r_hi     <= rd_data;
      if (r_state == ST_LATCH)  pix_data <= {r_hi, rd_data};
      if (w_adv) begin
        r_px <= w_px_wrap ? 3'd0 : r_px + 3'd1;
        if (w_px_wrap) begin
          r_py <= w_py_wrap ? 3'd0 : r_py + 3'd1;
          if (w_py_wrap) begin
            r_bx <= w_bx_wrap ? '0 : r_bx + c_BX_W'(1);
            if (w_bx_wrap) r_by <= w_by_wrap ? '0 : r_by + c_BY_W'(1);
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_block_reader.sv
`default_nettype none
// ============================================================================
// tb_block_reader : directed self-checking bench for block_reader
// Rev 1.0
// ============================================================================
module tb_block_reader;
  import block_reader_pkg::*;

  // V_RES reduced to two block rows so a complete frame stays short.
  localparam int H_RES  = 160;
  localparam int V_RES  = 16;
  localparam int N_BLK  = (H_RES / 8) * (V_RES / 8);
  localparam int N_PIX  = N_BLK * 64;
  localparam int LOG    = 256;

  logic        clk;
  logic        rst_n;
  logic        frame_captured;
  logic [15:0] rd_addr;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        blk_first;
  logic        blk_last;
  logic        frame_done;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt = 0, rd_cnt = 0, blast_cnt = 0, bfirst_cnt = 0, done_cnt = 0;
  bit log_en = 1'b1;
  logic [15:0] pix_log  [LOG];
  logic        first_log[LOG];
  logic        last_log [LOG];
  logic [15:0] hi_log   [LOG];

  block_reader #(
    .H_RES(H_RES), .V_RES(V_RES), .BUFF_BITS(16), .BASE_ADDR(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_captured(frame_captured),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .blk_first(blk_first), .blk_last(blk_last),
    .frame_done(frame_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame buffer: each byte holds the low 8 bits of its own address.
  always @(posedge clk) if (rd_en) rd_data <= rd_addr[7:0];

  always @(negedge clk) begin
    if (rd_en) begin
      if (log_en && rd_cnt[0] == 1'b0 && (rd_cnt >> 1) < LOG) hi_log[rd_cnt >> 1] = rd_addr;
      rd_cnt++;
    end
    if (pix_valid && pix_ready) begin
      if (log_en && hs_cnt < LOG) begin
        pix_log[hs_cnt]   = pix_data;
        first_log[hs_cnt] = blk_first;
        last_log[hs_cnt]  = blk_last;
      end
      hs_cnt++;
      if (blk_last)  blast_cnt++;
      if (blk_first) bfirst_cnt++;
    end
    if (frame_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input int target, input int budget);
    int n = 0;
    while (hs_cnt < target && n < budget) begin tick(); n++; end
    chk("wait_handshakes", 32'(hs_cnt >= target), 32'd1);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!pix_valid && n < budget) begin tick(); n++; end
    chk("wait_pix_valid", 32'(pix_valid), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {26'd0, rd_en, pix_valid, blk_first, blk_last, frame_done, busy}, 32'd0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    chk({tag, "_pix_data"}, 32'(pix_data), 32'd0);
  endtask

  initial begin
    logic [15:0] held;
    int rd_snap, drop, hs_base, errs_pix, errs_addr, n;
    int blk, bx, by, px, py, a;
    logic [15:0] e;

    rst_n = 1'b0; frame_captured = 1'b0; pix_ready = 1'b1;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Frame 1: start, check first read strobes.
    frame_captured = 1'b1;
    tick();
    chk("start_busy", 32'(busy), 32'd1);
    chk("first_hi_addr", {15'd0, rd_en, rd_addr}, {15'd0, 1'b1, 16'd1});
    tick();
    chk("first_lo_addr", {15'd0, rd_en, rd_addr}, {15'd0, 1'b1, 16'd2});

    // Back-pressure on pixel 5 (bytes at 11/12).
    wait_hs(5, 200);
    pix_ready = 1'b0;
    wait_valid(50);
    held = pix_data; rd_snap = rd_cnt; drop = 0;
    repeat (10) begin tick(); if (!pix_valid) drop++; end
    chk("stall_data", 32'(held), 32'h0B0C);
    chk("stall_valid_drop", 32'(drop), 32'd0);
    chk("stall_data_stable", 32'(pix_data), 32'(held));
    chk("stall_no_rd", 32'(rd_cnt), 32'(rd_snap));
    chk("stall_no_hs", 32'(hs_cnt), 32'd5);
    pix_ready = 1'b1;

    // A second frame_captured edge while busy must be ignored.
    wait_hs(200, 2000);
    frame_captured = 1'b0;
    tick();
    frame_captured = 1'b1;

    n = 0;
    while (!frame_done && n < 20000) begin tick(); n++; end
    chk("frame_done_seen", 32'(frame_done), 32'd1);
    chk("done_busy", 32'(busy), 32'd1);
    tick();
    chk("after_done_busy", {30'd0, busy, frame_done}, 32'd0);
    chk("hs_total", 32'(hs_cnt), 32'(N_PIX));
    chk("blk_last_total", 32'(blast_cnt), 32'(N_BLK));
    chk("blk_first_total", 32'(bfirst_cnt), 32'(N_BLK));
    chk("frame_done_pulses", 32'(done_cnt), 32'd1);
    log_en = 1'b0;

    chk("pix0", 32'(pix_log[0]), 32'h0102);
    chk("pix0_first", 32'(first_log[0]), 32'd1);
    chk("pix1", 32'(pix_log[1]), 32'h0304);
    chk("pix1_first", 32'(first_log[1]), 32'd0);
    chk("pix8_addr", 32'(hi_log[8]), 32'd321);
    chk("pix8", 32'(pix_log[8]), 32'h4142);
    chk("pix62_last", 32'(last_log[62]), 32'd0);
    chk("pix63_last", 32'(last_log[63]), 32'd1);
    chk("pix63", 32'(pix_log[63]), 32'hCFD0);
    chk("pix64_addr", 32'(hi_log[64]), 32'd17);
    chk("pix64", 32'(pix_log[64]), 32'h1112);
    chk("pix64_first", 32'(first_log[64]), 32'd1);
    chk("pix201", 32'(pix_log[201]), 32'h7374);

    errs_pix = 0; errs_addr = 0;
    for (int k = 0; k < LOG; k++) begin
      blk = k / 64; bx = blk % (H_RES / 8); by = blk / (H_RES / 8);
      py = (k % 64) / 8; px = k % 8;
      a = 1 + 2 * ((by * 8 + py) * H_RES + bx * 8 + px);
      e = {8'(a), 8'(a + 1)};
      if (pix_log[k] !== e)      errs_pix++;
      if (hi_log[k] !== 16'(a))  errs_addr++;
    end
    chk("seq_pixels", 32'(errs_pix), 32'd0);
    chk("seq_addrs", 32'(errs_addr), 32'd0);

    repeat (20) tick();
    chk("no_restart_level", 32'(busy), 32'd0);

    // Frame 2: reset mid-frame.
    frame_captured = 1'b0;
    tick();
    frame_captured = 1'b1;
    hs_base = hs_cnt;
    wait_hs(hs_base + 1000, 8000);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("held_high_no_start", 32'(busy), 32'd0);

    frame_captured = 1'b0;
    tick();
    frame_captured = 1'b1;
    tick();
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_hi_addr", {15'd0, rd_en, rd_addr}, {15'd0, 1'b1, 16'd1});
    wait_valid(10);
    chk("restart_pix0", 32'(pix_data), 32'h0102);
    chk("restart_first", 32'(blk_first), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
